// File: rtl/mario_dma_ctrl.sv
// Sprite DMA sequencer: copies LEN bytes from main RAM 7A port B into sprite RAM.
// Optional feature macro MARIO_DMA_VBL_SYNC_EN holds transfer starts until vblank.
module mario_dma_ctrl #(
    parameter int unsigned     AW       = 10,
    parameter int unsigned     LEN      = 384,
    parameter logic [AW-1:0]   SRC_BASE = 10'h100,
    parameter logic [AW-1:0]   DST_BASE = 10'h000
) (
    input  logic          I_CLK,
    input  logic          I_RESET,
    input  logic          I_DMA_TRIG,
    input  logic          I_VBLK_n,
    input  logic          I_SRC_GNT,
    input  logic [7:0]    I_DMA_DS,
    output logic [AW-1:0] O_DMA_AS,
    output logic          O_DMA_CES,
    output logic [AW-1:0] O_DMA_AD,
    output logic [7:0]    O_DMA_DD,
    output logic          O_DMA_CED,
    output logic          O_BUSY,
    output logic          O_DONE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] LAST_IDX = (AW+1)'(LEN - 1);

    state_t        state_r;
    state_t        state_nx_s;
    logic [AW-1:0] idx_r;
    logic [AW-1:0] idx_nx_s;
    logic          pending_r;
    logic          pending_nx_s;
    logic          trig_q_r;
    logic          edge_s;
    logic          req_s;
    logic          start_ok_s;
    logic          go_run_s;
    logic          ces_s;
    logic [AW-1:0] as_s;
    logic          rd_v_r;
    logic [AW-1:0] rd_idx_r;
    logic          ced_r;
    logic [AW-1:0] ad_r;
    logic [7:0]    dd_r;
    logic          busy_r;
    logic          done_r;

    assign edge_s = I_DMA_TRIG & ~trig_q_r;
    assign req_s  = edge_s | pending_r;

`ifdef MARIO_DMA_VBL_SYNC_EN
    assign start_ok_s = ~I_VBLK_n;
`else
    logic vblk_unused_s;
    assign vblk_unused_s = I_VBLK_n;
    assign start_ok_s    = 1'b1;
`endif

    // Next-state, read-side strobe/address and pending-request bookkeeping
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        go_run_s   = 1'b0;
        ces_s      = 1'b0;
        as_s       = {AW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (req_s && start_ok_s) begin
                    go_run_s   = 1'b1;
                    state_nx_s = ST_RUN;
                    idx_nx_s   = {AW{1'b0}};
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // The read strobe follows this cycle's grant so no read issues ungranted
                if (I_SRC_GNT) begin
                    ces_s = 1'b1;
                    as_s  = SRC_BASE + idx_r;
                    if ({1'b0, idx_r} == LAST_IDX) begin
                        state_nx_s = ST_DRAIN;
                        idx_nx_s   = {AW{1'b0}};
                    end else begin
                        idx_nx_s = idx_r + {{(AW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    idx_nx_s = idx_r;
                end
            end
            ST_DRAIN: begin
                if (!rd_v_r) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (req_s && start_ok_s) begin
                    go_run_s   = 1'b1;
                    state_nx_s = ST_RUN;
                    idx_nx_s   = {AW{1'b0}};
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                idx_nx_s   = {AW{1'b0}};
            end
        endcase
        if (go_run_s) begin
            pending_nx_s = 1'b0;
        end else begin
            pending_nx_s = pending_r | edge_s;
        end
    end

    // State, index, trigger history and the two-stage write pipeline
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_r   <= ST_IDLE;
            idx_r     <= {AW{1'b0}};
            pending_r <= 1'b0;
            trig_q_r  <= 1'b1;
            rd_v_r    <= 1'b0;
            rd_idx_r  <= {AW{1'b0}};
            ced_r     <= 1'b0;
            ad_r      <= {AW{1'b0}};
            dd_r      <= 8'h00;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            idx_r     <= idx_nx_s;
            pending_r <= pending_nx_s;
            trig_q_r  <= I_DMA_TRIG;
            rd_v_r    <= ces_s;
            rd_idx_r  <= idx_r;
            ced_r     <= rd_v_r;
            ad_r      <= rd_v_r ? (DST_BASE + rd_idx_r) : {AW{1'b0}};
            dd_r      <= rd_v_r ? I_DMA_DS : 8'h00;
            busy_r    <= (state_nx_s == ST_RUN) || (state_nx_s == ST_DRAIN);
            done_r    <= (state_nx_s == ST_DONE);
        end
    end

    assign O_DMA_CES = ces_s;
    assign O_DMA_AS  = as_s;
    assign O_DMA_CED = ced_r;
    assign O_DMA_AD  = ad_r;
    assign O_DMA_DD  = dd_r;
    assign O_BUSY    = busy_r;
    assign O_DONE    = done_r;

endmodule

// File: tb/tb_mario_dma_ctrl.sv
// Self-checking bench for mario_dma_ctrl: LEN=1 vector table plus transfer-level reference model.
module tb_mario_dma_ctrl;

    localparam int         LEN = 384;
    localparam logic [9:0] SRC = 10'h100;
    localparam logic [9:0] DST = 10'h000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (default parameters)
    logic       rst = 1'b1, trig = 1'b0, vblk_n = 1'b0, gnt = 1'b0;
    logic [7:0] ds = 8'h00;
    logic [9:0] as_o, ad_o;
    logic [7:0] dd_o;
    logic       ces_o, ced_o, busy_o, done_o;

    mario_dma_ctrl dut (
        .I_CLK(clk), .I_RESET(rst), .I_DMA_TRIG(trig), .I_VBLK_n(vblk_n),
        .I_SRC_GNT(gnt), .I_DMA_DS(ds),
        .O_DMA_AS(as_o), .O_DMA_CES(ces_o), .O_DMA_AD(ad_o), .O_DMA_DD(dd_o),
        .O_DMA_CED(ced_o), .O_BUSY(busy_o), .O_DONE(done_o)
    );

    // single-byte instance at the top of the address space
    logic       rst1 = 1'b1, trig1 = 1'b0, gnt1 = 1'b0;
    logic [7:0] ds1 = 8'h00;
    logic [9:0] as1, ad1;
    logic [7:0] dd1;
    logic       ces1, ced1, busy1, done1;

    mario_dma_ctrl #(.AW(10), .LEN(1), .SRC_BASE(10'h3FF), .DST_BASE(10'h3FF)) dut1 (
        .I_CLK(clk), .I_RESET(rst1), .I_DMA_TRIG(trig1), .I_VBLK_n(1'b0),
        .I_SRC_GNT(gnt1), .I_DMA_DS(ds1),
        .O_DMA_AS(as1), .O_DMA_CES(ces1), .O_DMA_AD(ad1), .O_DMA_DD(dd1),
        .O_DMA_CED(ced1), .O_BUSY(busy1), .O_DONE(done1)
    );

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       t;
        logic       g;
        logic [7:0] ds;
        logic       busy;
        logic       done;
        logic       ces;
        logic [9:0] as;
        logic       ced;
        logic [9:0] ad;
        logic [7:0] dd;
    } vec_t;

    vec_t vt[18];

    // reference model state: one transfer = LEN reads at granted cycles, writes 2 cycles later,
    // done 3 cycles after the last read, then a pending request restarts immediately
    typedef struct { int due; logic [9:0] ad; logic [7:0] dd; } wr_t;
    wr_t  wq[$];
    bit   m_busy = 1'b0, m_done = 1'b0, m_pend = 1'b0, m_prev_trig = 1'b1;
    int   m_rd = 0, m_fin_at = -100, m_done_cnt = 0, m_wr_cnt = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    logic p_ces = 1'b0;
    logic [9:0] p_as = 10'h000;
    bit   prev_busy = 1'b0;

    int wr_cnt, done_cnt, ces_cnt, busy_cnt, first_ces;
    int rise_q[$];
    int done_q[$];

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic clr();
        wr_cnt = 0; done_cnt = 0; ces_cnt = 0; busy_cnt = 0; first_ces = -1;
        m_done_cnt = 0; m_wr_cnt = 0;
        rise_q.delete(); done_q.delete();
    endtask

    // one clock cycle on the main instance: drive, sample at negedge, compare, advance model
    task automatic step(input logic t, input logic g, input logic v, input logic r);
        logic       edge_v, start_ok, e_ces, e_ced;
        logic [9:0] e_as, e_ad;
        logic [7:0] e_dd;
        logic [31:0] exp_v, act_v;
        @(posedge clk); #1;
        cyc++;
        ds = p_ces ? p_as[7:0] : 8'($urandom);
        trig = t; gnt = g; vblk_n = v; rst = r;
        @(negedge clk);
        e_ces = m_busy && (m_rd < LEN) && g;
        e_as  = e_ces ? 10'(SRC + m_rd) : 10'h000;
        e_ced = (wq.size() > 0) && (wq[0].due == cyc);
        e_ad  = e_ced ? wq[0].ad : 10'h000;
        e_dd  = e_ced ? wq[0].dd : 8'h00;
        exp_v = {m_busy, m_done, e_ces, e_as, e_ced, e_ad, e_dd};
        act_v = {busy_o, done_o, ces_o, as_o, ced_o, ad_o, dd_o};
        if (chk_en) begin
            n_chk++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle%0d outputs: got busy=%b done=%b ces=%b as=%h ced=%b ad=%h dd=%h, expected busy=%b done=%b ces=%b as=%h ced=%b ad=%h dd=%h",
                         cyc, busy_o, done_o, ces_o, as_o, ced_o, ad_o, dd_o,
                         m_busy, m_done, e_ces, e_as, e_ced, e_ad, e_dd);
            end
        end
        if (ced_o === 1'b1) wr_cnt++;
        if (done_o === 1'b1) begin done_cnt++; done_q.push_back(cyc); end
        if (ces_o === 1'b1) begin ces_cnt++; if (first_ces < 0) first_ces = cyc; end
        if (busy_o === 1'b1) busy_cnt++;
        if (busy_o === 1'b1 && !prev_busy) rise_q.push_back(cyc);
        prev_busy = (busy_o === 1'b1);
        if (e_ced) begin void'(wq.pop_front()); m_wr_cnt++; end
        if (m_done) m_done_cnt++;
        p_ces = ces_o; p_as = as_o;
        edge_v = t && !m_prev_trig;
`ifdef MARIO_DMA_VBL_SYNC_EN
        start_ok = !v;
`else
        start_ok = 1'b1;
`endif
        if (r) begin
            m_busy = 1'b0; m_done = 1'b0; m_pend = 1'b0; m_prev_trig = 1'b1;
            m_rd = 0; m_fin_at = -100; wq.delete();
        end else begin
            m_prev_trig = t;
            if (e_ces) begin
                wq.push_back('{cyc + 2, 10'(DST + m_rd), 8'(SRC + m_rd)});
                m_rd++;
                if (m_rd == LEN) m_fin_at = cyc + 3;
            end
            if (m_busy) begin
                m_pend = m_pend | edge_v;
                m_done = (cyc + 1 == m_fin_at);
                if (m_done) m_busy = 1'b0;
            end else begin
                m_done = 1'b0;
                if ((edge_v || m_pend) && start_ok) begin
                    m_busy = 1'b1; m_rd = 0; m_pend = 1'b0;
                end else begin
                    m_pend = m_pend | edge_v;
                end
            end
        end
    endtask

    initial begin
        // LEN=1 table: t g ds | busy done ces as ced ad dd
        vt[0]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 8'h00};
        vt[1]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 8'h00};
        vt[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 8'h00};
        vt[3]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 10'h3FF, 1'b0, 10'h000, 8'h00};
        vt[4]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 8'h00};
        vt[5]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 10'h3FF, 8'hA5};
        vt[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 8'h00};
        vt[7]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 8'h00};
        vt[8]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 8'h00};
        vt[9]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 10'h3FF, 1'b0, 10'h000, 8'h00};
        vt[10] = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 8'h00};
        vt[11] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 10'h3FF, 8'h5A};
        vt[12] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 8'h00};
        vt[13] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 10'h3FF, 1'b0, 10'h000, 8'h00};
        vt[14] = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 8'h00};
        vt[15] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 10'h3FF, 8'h77};
        vt[16] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 8'h00};
        vt[17] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 8'h00};

        // single-byte instance: reset, then table (main instance held in reset meanwhile)
        repeat (2) @(posedge clk);
        #1 rst1 = 1'b0;
        for (int i = 0; i < 18; i++) begin
            logic [31:0] e1, a1;
            trig1 = vt[i].t; gnt1 = vt[i].g; ds1 = vt[i].ds;
            @(negedge clk);
            e1 = {vt[i].busy, vt[i].done, vt[i].ces, vt[i].as, vt[i].ced, vt[i].ad, vt[i].dd};
            a1 = {busy1, done1, ces1, as1, ced1, ad1, dd1};
            n_chk++;
            if (a1 !== e1) begin
                n_fail++;
                $display("FAIL len1_row%0d: got busy=%b done=%b ces=%b as=%h ced=%b ad=%h dd=%h, expected %h",
                         i, busy1, done1, ces1, as1, ced1, ad1, dd1, e1);
            end
            @(posedge clk); #1;
        end

        // main instance reset: first cycle unchecked (outputs not yet defined)
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // continuous grant, single trigger pulse
        clr();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t1_writes", wr_cnt, LEN);
        check("t1_done_count", done_cnt, 1);
        check("t1_busy_cycles", busy_cnt, LEN + 2);
        check("t1_done_latency", (done_q.size() > 0 && rise_q.size() > 0) ? done_q[0] - rise_q[0] : -1, LEN + 2);

        // ~50% random grant
        clr();
        step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        for (int i = 0; i < 4000 && done_cnt == 0; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("t2_done_count", done_cnt, 1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("t2_writes", wr_cnt, LEN);
        check("t2_done_count_after", done_cnt, 1);

        // retrigger edges during the transfer collapse into one pending start
        clr();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 900; i++) step(1'((i == 100) || (i == 200)), 1'b1, 1'b0, 1'b0);
        check("t3_writes", wr_cnt, 2 * LEN);
        check("t3_done_count", done_cnt, 2);
        check("t3_restart_gap", (rise_q.size() > 1 && done_q.size() > 0) ? rise_q[1] - done_q[0] : -1, 1);

        // reset mid-transfer with the trigger held high
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        clr();
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t4_ces_after_reset", ces_cnt, 0);
        check("t4_writes_after_reset", wr_cnt, 0);
        check("t4_done_after_reset", done_cnt, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t4_restart_writes", wr_cnt, LEN);
        check("t4_restart_done", done_cnt, 1);

`ifdef MARIO_DMA_VBL_SYNC_EN
        // start held off until vblank, then runs to completion outside vblank
        begin
            int vlow_c;
            clr();
            step(1'b1, 1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
            check("t5_ces_outside_vblank", ces_cnt, 0);
            step(1'b0, 1'b1, 1'b0, 1'b0);
            vlow_c = cyc;
            for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 400; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
            check("t5_first_ces", first_ces, vlow_c + 1);
            check("t5_writes", wr_cnt, LEN);
            check("t5_done", done_cnt, 1);
        end
`endif

        // random triggers, grant, vblank and rare resets against the model
        begin
            logic tr, vb;
            tr = 1'b0; vb = 1'b0;
            clr();
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 39) == 0) tr = ~tr;
                if ($urandom_range(0, 59) == 0) vb = ~vb;
                step(tr, 1'($urandom_range(0, 3) != 0), vb, 1'($urandom_range(0, 1499) == 0));
            end
            for (int i = 0; i < 1600; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
            check("rnd_done_count", done_cnt, m_done_cnt);
            check("rnd_write_count", wr_cnt, m_wr_cnt);
            check("rnd_queue_drained", wq.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
